// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit packet sequencer.
//   tx_state_t   : sequencer FSM states
//   byte_sel_t   : byte_out source selection for usb_tx_byte_mux
//   PID_TYPE_*   : PID type field values (pid[1:0])
//   PID_*        : PID nibbles used by the device path
//   SYNC_DEFAULT : default sync byte (0x80, sent LSB-first)
package usb_tx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_WAIT,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_DONE,
        ST_ABORT
    } tx_state_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_SYNC,
        SEL_PID,
        SEL_FIFO,
        SEL_CRC_LO,
        SEL_CRC_HI
    } byte_sel_t;

    localparam logic [1:0] PID_TYPE_DATA = 2'b11;
    localparam logic [1:0] PID_TYPE_HS   = 2'b10;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [7:0] SYNC_DEFAULT = 8'h80;

    // PID byte on the wire: check nibble (complement) in the upper half.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_pkt_sequencer_byte_mux.sv
// usb_tx_byte_mux: combinational source select for the serializer byte.
//   sel        in  3  byte_sel_t code from the sequencer FSM
//   pid        in  4  latched PID nibble
//   fifo_rdata in  8  FIFO head byte
//   crc        in 16  captured CRC16 value
//   byte_out   out 8  selected byte (0x00 when nothing is selected)
module usb_tx_byte_mux
    import usb_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic [2:0]  sel,
    input  logic [3:0]  pid,
    input  logic [7:0]  fifo_rdata,
    input  logic [15:0] crc,
    output logic [7:0]  byte_out
);

    always_comb begin
        byte_out = '0;
        case (sel)
            SEL_SYNC:   byte_out = SYNC_BYTE;
            SEL_PID:    byte_out = pid_byte(pid);
            SEL_FIFO:   byte_out = fifo_rdata;
            SEL_CRC_LO: byte_out = crc[7:0];
            SEL_CRC_HI: byte_out = crc[15:8];
            default:    byte_out = '0;
        endcase
    end

endmodule

// File: rtl/usb_tx_pkt_sequencer.sv
// usb_tx_pkt_sequencer: byte-level USB transmit packet sequencer.
// Emits SYNC, PID, payload (data PIDs), CRC16 (data PIDs) and an EOP request
// towards the bit-level serializer over a valid/ready byte handshake.
//   clk, n_rst          clock, synchronous active-low reset
//   tx_start/pid/len    packet request (sampled in IDLE only)
//   fifo_rdata/empty/re first-word-fall-through transmit FIFO
//   crc_clear/enable    control of the external CRC16 generator
//   crc_value           CRC16 result from the generator
//   byte_out/valid/ready byte handshake to the serializer
//   eop_req/eop_done    EOP request level / completion pulse
//   tx_busy/done/error  packet status
module usb_tx_pkt_sequencer
    import usb_tx_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 64,
    parameter int         LEN_W          = $clog2(MAX_PAYLOAD + 1),
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         UNDERRUN_LIMIT = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_re,
    output logic             crc_clear,
    output logic             crc_enable,
    input  logic [15:0]      crc_value,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             eop_req,
    input  logic             eop_done,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_error
);

    localparam int UR_W = $clog2(UNDERRUN_LIMIT + 1);

    tx_state_t        state;
    byte_sel_t        byte_sel;
    logic [3:0]       pid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [15:0]      crc_q;
    logic [UR_W-1:0]  ur_cnt;
    logic             abort_q;
    logic             xfer;

    // Handshake outputs follow the state and the FIFO flag directly so that a
    // FWFT byte is offered in the same cycle it appears.
    always_comb begin
        byte_sel   = SEL_NONE;
        byte_valid = 1'b0;
        case (state)
            ST_SYNC:   begin byte_sel = SEL_SYNC;   byte_valid = 1'b1;        end
            ST_PID:    begin byte_sel = SEL_PID;    byte_valid = 1'b1;        end
            ST_DATA:   begin byte_sel = SEL_FIFO;   byte_valid = ~fifo_empty; end
            ST_CRC_LO: begin byte_sel = SEL_CRC_LO; byte_valid = 1'b1;        end
            ST_CRC_HI: begin byte_sel = SEL_CRC_HI; byte_valid = 1'b1;        end
            default:   ;
        endcase
    end

    assign xfer       = byte_valid & byte_ready;
    assign fifo_re    = xfer & (state == ST_DATA);
    assign crc_enable = xfer & (state == ST_DATA);

    usb_tx_byte_mux #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_byte_mux (
        .sel        (byte_sel),
        .pid        (pid_q),
        .fifo_rdata (fifo_rdata),
        .crc        (crc_q),
        .byte_out   (byte_out)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            pid_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            ur_cnt    <= '0;
            abort_q   <= 1'b0;
            crc_clear <= 1'b0;
            eop_req   <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_error  <= 1'b0;
        end else begin
            crc_clear <= 1'b0;
            tx_done   <= 1'b0;
            tx_error  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        if (tx_pid[1:0] == PID_TYPE_DATA && tx_len > LEN_W'(MAX_PAYLOAD)) begin
                            tx_error <= 1'b1;
                        end else begin
                            pid_q     <= tx_pid;
                            len_q     <= tx_len;
                            crc_clear <= 1'b1;
                            tx_busy   <= 1'b1;
                            abort_q   <= 1'b0;
                            state     <= ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    if (xfer) state <= ST_PID;
                end
                ST_PID: begin
                    // The cleared generator value is tracked here so a
                    // zero-length packet, which skips CRC_WAIT, still sends it.
                    crc_q <= crc_value;
                    if (xfer) begin
                        if (pid_q[1:0] != PID_TYPE_DATA) begin
                            eop_req <= 1'b1;
                            state   <= ST_EOP;
                        end else if (len_q == '0) begin
                            state <= ST_CRC_LO;
                        end else begin
                            cnt_q  <= len_q;
                            ur_cnt <= '0;
                            state  <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        ur_cnt <= '0;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) state <= ST_CRC_WAIT;
                    end else if (fifo_empty) begin
                        if (ur_cnt == UR_W'(UNDERRUN_LIMIT - 1)) begin
                            tx_error <= 1'b1;
                            state    <= ST_ABORT;
                        end else begin
                            ur_cnt <= ur_cnt + 1'b1;
                        end
                    end
                end
                ST_CRC_WAIT: begin
                    crc_q <= crc_value;
                    state <= ST_CRC_LO;
                end
                ST_CRC_LO: begin
                    if (xfer) state <= ST_CRC_HI;
                end
                ST_CRC_HI: begin
                    if (xfer) begin
                        eop_req <= 1'b1;
                        state   <= ST_EOP;
                    end
                end
                ST_EOP: begin
                    if (eop_done) begin
                        eop_req <= 1'b0;
                        if (abort_q) begin
                            tx_busy <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            tx_done <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_ABORT: begin
                    abort_q <= 1'b1;
                    eop_req <= 1'b1;
                    state   <= ST_EOP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/usb_tx_pkt_sequencer.md
Name: usb_tx_pkt_sequencer

Overview:
Parametrised byte-level transmit packet sequencer for the USB device path. It replaces the hard-wired transmit controller with a generic sequencer that emits SYNC, PID, a variable-length payload, an optional CRC16, and an EOP request. It sits between the transmit FIFO / CRC16 generator and the bit-level serializer (NRZI + bit-stuff). Handshakes are valid/ready, so serializer stalls never drop or repeat bytes.

Parameters:
MAX_PAYLOAD, 64, maximum data bytes per packet (1..1023)
LEN_W, $clog2(MAX_PAYLOAD+1), width of tx_len and the internal byte counter
SYNC_BYTE, 8'h80, sync pattern, sent LSB-first by the serializer
UNDERRUN_LIMIT, 16, cycles the sequencer waits on an empty FIFO mid-payload before aborting (>=1)

Ports:
clk  in  1  system clock
n_rst  in  1  reset; synchronous, active-low
tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE
tx_pid  in  4  PID nibble; {pid[1:0]==2'b11} = data PID, {pid[1:0]==2'b10} = handshake PID
tx_len  in  LEN_W  payload byte count for data PIDs; ignored for handshake PIDs
fifo_rdata  in  8  FIFO head byte (first-word-fall-through)
fifo_empty  in  1  FIFO empty flag
fifo_re  out  1  FIFO pop; one cycle per accepted payload byte
crc_clear  out  1  clears the external CRC16 generator
crc_enable  out  1  CRC16 accumulates byte_out this cycle
crc_value  in  16  CRC16 result; stable one cycle after the last crc_enable
byte_out  out  8  byte to the serializer
byte_valid  out  1  byte_out is valid
byte_ready  in  1  serializer accepts the byte
eop_req  out  1  level; request EOP, held until eop_done
eop_done  in  1  serializer finished EOP (one-cycle pulse)
tx_busy  out  1  high from the accepted tx_start until the DONE state exits
tx_done  out  1  one-cycle pulse; packet completed normally
tx_error  out  1  one-cycle pulse; packet rejected or aborted

Behaviour:
- Reset (n_rst low at posedge clk): state=IDLE, counter=0, all outputs 0, byte_out=8'h00. Applying reset mid-packet abandons the packet with no eop_req and no pulses.
- Transfer rule: a byte is consumed only on a cycle with byte_valid & byte_ready. byte_out and byte_valid must hold stable while byte_ready is low.
- IDLE: on tx_start, latch tx_pid and tx_len, assert crc_clear for one cycle, and go to SYNC.
  - tx_start with a data PID and tx_len > MAX_PAYLOAD: pulse tx_error, stay in IDLE, tx_busy stays 0.
  - tx_start while not IDLE is ignored.
- SYNC: byte_out=SYNC_BYTE, valid. On transfer -> PID.
- PID: byte_out={~pid,pid}. On transfer:
  - handshake PID -> EOP
  - data PID with len==0 -> CRC_LO
  - otherwise -> DATA, counter=len
- DATA: byte_valid = ~fifo_empty, byte_out=fifo_rdata. On transfer: fifo_re=1, crc_enable=1, counter-1. Counter reaching 0 -> CRC_WAIT.
  - While fifo_empty, an underrun counter increments. When it reaches UNDERRUN_LIMIT -> ABORT. The counter resets on every transfer.
- CRC_WAIT: one cycle, no valid (CRC settle) -> CRC_LO.
- CRC_LO: byte_out=crc_value[7:0]. On transfer -> CRC_HI.
- CRC_HI: byte_out=crc_value[15:8]. On transfer -> EOP. The CRC value must be captured in CRC_WAIT so later FIFO activity cannot change it.
- Zero-length data packet: PID -> CRC_LO directly. The crc_value of the cleared generator is sent, giving 0x0000 with the standard complement convention.
- EOP: eop_req=1, byte_valid=0. On eop_done -> DONE.
- DONE: tx_done=1 for one cycle -> IDLE.
- ABORT: pulse tx_error and drop byte_valid. The remaining bytes for this packet are not popped, and the FIFO is not drained. Then go to EOP; the EOP serves as the abort marker, and it exits via a dedicated path to IDLE without tx_done.
- eop_done outside the EOP state is ignored. byte_ready when byte_valid=0 is ignored.
- Counter width is LEN_W; no wrap, because len is range-checked in IDLE.
- States are SYNC, PID, DATA, CRC_WAIT, CRC_LO, CRC_HI, EOP, DONE, ABORT, IDLE. Encoding is a one-hot or binary enum in the package.

Decomposition:
- Package usb_tx_pkg holds:
  - the state enum
  - PID type constants (PID_TYPE_DATA=2'b11, PID_TYPE_HS=2'b10)
  - PID values ACK=4'b0010, NAK=4'b1010, DATA0=4'b0011, DATA1=4'b1011
  - SYNC default
- One sub-module, usb_tx_byte_mux: combinational selection of byte_out from SYNC/PID/FIFO/CRC. The FSM, counters and handshake stay in the top module.

Test Plan:
- ACK: tx_start, pid=4'b0010, serializer always ready -> bytes 0x80, 0xD2; then eop_req; eop_done -> tx_done pulse; no fifo_re or crc_enable.
- DATA0 len=3, FIFO {0x01,0x02,0x03}, crc_value=0xABCD -> bytes 0x80, 0xC3, 0x01, 0x02, 0x03, 0xCD, 0xAB; exactly 3 fifo_re and 3 crc_enable pulses; one CRC_WAIT gap before 0xCD.
- Backpressure: same packet with byte_ready toggling 1-in-3 -> identical byte sequence; byte_out stable while valid and not ready; no duplicated fifo_re.
- Zero-length DATA1 -> 0x80, 0x4B, CRC low, CRC high; no fifo_re.
- Errors and reset:
  - FIFO empty after 1 of 4 bytes, UNDERRUN_LIMIT=16 -> tx_error exactly 16 cycles after the stall, then eop_req, then IDLE without tx_done.
  - tx_len=MAX_PAYLOAD+1 -> immediate tx_error, tx_busy never set.
  - n_rst low during DATA -> next cycle all outputs 0, IDLE.
